// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions.
//   PSUM_W         : width of a partial sum
//   psum_t         : signed partial-sum type
//   psum_state_e   : accumulator FSM states
package tpu_pkg;

    localparam int PSUM_W = 12;

    typedef logic signed [PSUM_W-1:0] psum_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } psum_state_e;

endpackage

// File: rtl/psum_accum_if.sv
// Stream bundle between the partial-sum adder, the accumulator and the
// tile consumer.
//   in_valid/in_ready/in_data   : partial-sum beat stream into the accumulator
//   out_valid/out_ready         : tile result handshake
//   out_data/out_ovf            : tile sum and its signed-overflow flag
// modport slave  : the accumulator side
// modport master : the producer/consumer side driving the accumulator
interface psum_accum_if
    import tpu_pkg::*;
#(
    parameter int N = PSUM_W
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );
endinterface

// File: rtl/psum_add_ovf.sv
// Combinational N-bit wrap-around adder with signed-overflow detect.
//   a, b : two's-complement operands
//   sum  : a + b modulo 2^N (carry-out dropped)
//   ovf  : operands share a sign and the sum has the other sign
module psum_add_ovf #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         ovf
);
    always_comb begin
        sum = a + b;
        ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    end
endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: adds K consecutive beats into one tile result
// (mod 2^N) and presents it on a one-entry registered output with a
// sticky signed-overflow flag.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : psum_accum_if slave (input beat stream, tile output stream)
//
// state | meaning
// ------+---------------------------------------
// IDLE  | cnt == 0, no tile in progress
// ACCUM | 0 < cnt <= K-1, tile partially summed
module psum_accum
    import tpu_pkg::*;
#(
    parameter int  N  = PSUM_W,
    parameter int  K  = 4,
    localparam int CW = (K > 1) ? $clog2(K) : 1
) (
    input logic          clk,
    input logic          rst,
    psum_accum_if.slave  bus
);
    localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

    psum_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          ovf_acc_q, ovf_acc_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_ovf_q, out_ovf_d;

    logic          first_beat;
    logic          last_beat;
    logic          accept_in;
    logic          consume;
    logic [N-1:0]  add_sum;
    logic          add_ovf;
    logic [N-1:0]  fin_data;
    logic          fin_ovf;

    psum_add_ovf #(.N(N)) u_add (
        .a   (acc_q),
        .b   (bus.in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // With K == 1 every beat is both first and last.
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST_CNT);

    // Only the final beat can be blocked, and only by an undrained output.
    assign bus.in_ready = !(last_beat && out_valid_q && !bus.out_ready);
    assign accept_in    = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_q && bus.out_ready;

    assign fin_data = first_beat ? bus.in_data : add_sum;
    assign fin_ovf  = first_beat ? 1'b0 : (ovf_acc_q | add_ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q && !consume;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (accept_in) begin
            if (last_beat) begin
                // Final beat goes straight to the output slot; acc is left alone.
                out_valid_d = 1'b1;
                out_data_d  = fin_data;
                out_ovf_d   = fin_ovf;
                cnt_d       = '0;
                state_d     = IDLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = ACCUM;
                if (first_beat) begin
                    acc_d     = bus.in_data;
                    ovf_acc_d = 1'b0;
                end else begin
                    acc_d     = add_sum;
                    ovf_acc_d = ovf_acc_q | add_ovf;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a K=4 instance and a K=1 instance share
// clock and reset. Inputs change and outputs are sampled just after the
// falling edge, away from the rising edge where the DUT updates.
module tb_psum_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    psum_accum_if #(.N(12)) bus4 ();
    psum_accum_if #(.N(12)) bus1 ();

    psum_accum #(.N(12), .K(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    psum_accum #(.N(12), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv4(input logic v, input logic [11:0] d, input logic ordy);
        @(negedge clk);
        bus4.in_valid  = v;
        bus4.in_data   = d;
        bus4.out_ready = ordy;
        #1;
    endtask

    task automatic drv1(input logic v, input logic [11:0] d, input logic ordy);
        @(negedge clk);
        bus1.in_valid  = v;
        bus1.in_data   = d;
        bus1.out_ready = ordy;
        #1;
    endtask

    task automatic out4(input string tag, input logic v, input logic [11:0] d, input logic o);
        chk({tag, ".valid"}, 32'(bus4.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bus4.out_data),  32'(d));
        chk({tag, ".ovf"},   32'(bus4.out_ovf),   32'(o));
    endtask

    task automatic out1(input string tag, input logic v, input logic [11:0] d, input logic o);
        chk({tag, ".valid"}, 32'(bus1.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bus1.out_data),  32'(d));
        chk({tag, ".ovf"},   32'(bus1.out_ovf),   32'(o));
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        out4("rst4", 1'b0, 12'h000, 1'b0);
        chk("rst4.in_ready", 32'(bus4.in_ready), 32'd1);
        out1("rst1", 1'b0, 12'h000, 1'b0);
        chk("rst1.in_ready", 32'(bus1.in_ready), 32'd1);

        // Basic tile 1+2+3+4 = 10
        drv4(1'b1, 12'd1, 1'b1);
        drv4(1'b1, 12'd2, 1'b1);
        out4("t1.mid", 1'b0, 12'h000, 1'b0);
        drv4(1'b1, 12'd3, 1'b1);
        drv4(1'b1, 12'd4, 1'b1);
        chk("t1.rdy_last", 32'(bus4.in_ready), 32'd1);
        drv4(1'b0, 12'd0, 1'b1);
        out4("t1.res", 1'b1, 12'd10, 1'b0);
        drv4(1'b0, 12'd0, 1'b1);
        out4("t1.drained", 1'b0, 12'd10, 1'b0);

        // Signed overflow 0x7FF + 0x001, then a clean tile 5,-5,0,0
        drv4(1'b1, 12'h7FF, 1'b1);
        drv4(1'b1, 12'h001, 1'b1);
        drv4(1'b1, 12'h000, 1'b1);
        drv4(1'b1, 12'h000, 1'b1);
        drv4(1'b1, 12'h005, 1'b1);
        out4("t2.wrap", 1'b1, 12'h800, 1'b1);
        drv4(1'b1, 12'hFFB, 1'b1);
        out4("t2.gap", 1'b0, 12'h800, 1'b1);
        drv4(1'b1, 12'h000, 1'b1);
        drv4(1'b1, 12'h000, 1'b1);
        drv4(1'b0, 12'h000, 1'b1);
        out4("t2.clean", 1'b1, 12'h000, 1'b0);

        // Backpressure: tile A = 4 held, tile B = 2+2+2+3 = 9 stalls on its last beat
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd2, 1'b0);
        out4("t3.A", 1'b1, 12'd4, 1'b0);
        chk("t3.rdy_b1", 32'(bus4.in_ready), 32'd1);
        drv4(1'b1, 12'd2, 1'b0);
        chk("t3.rdy_b2", 32'(bus4.in_ready), 32'd1);
        drv4(1'b1, 12'd2, 1'b0);
        chk("t3.rdy_b3", 32'(bus4.in_ready), 32'd1);
        drv4(1'b1, 12'd3, 1'b0);
        chk("t3.rdy_b4", 32'(bus4.in_ready), 32'd0);
        out4("t3.hold1", 1'b1, 12'd4, 1'b0);
        drv4(1'b1, 12'd3, 1'b0);
        chk("t3.rdy_stall", 32'(bus4.in_ready), 32'd0);
        out4("t3.hold2", 1'b1, 12'd4, 1'b0);
        drv4(1'b1, 12'd3, 1'b1);
        chk("t3.rdy_drain", 32'(bus4.in_ready), 32'd1);
        out4("t3.hold3", 1'b1, 12'd4, 1'b0);
        drv4(1'b0, 12'd0, 1'b1);
        out4("t3.B", 1'b1, 12'd9, 1'b0);
        drv4(1'b0, 12'd0, 1'b1);
        out4("t3.done", 1'b0, 12'd9, 1'b0);

        // Sustained stream of -1: two tiles of 0xFFC with no bubbles
        for (int i = 0; i < 8; i++) begin
            drv4(1'b1, 12'hFFF, 1'b1);
            chk($sformatf("t4.rdy%0d", i), 32'(bus4.in_ready), 32'd1);
            if (i == 4) out4("t4.r0", 1'b1, 12'hFFC, 1'b0);
            if (i == 5) chk("t4.gap", 32'(bus4.out_valid), 32'd0);
        end
        drv4(1'b0, 12'd0, 1'b1);
        out4("t4.r1", 1'b1, 12'hFFC, 1'b0);

        // Reset mid-tile with a pending output
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd1, 1'b0);
        drv4(1'b1, 12'd7, 1'b0);
        out4("t5.pend", 1'b1, 12'd4, 1'b0);
        drv4(1'b1, 12'd7, 1'b0);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        out4("t5.rst", 1'b0, 12'd0, 1'b0);
        chk("t5.rdy", 32'(bus4.in_ready), 32'd1);
        drv4(1'b1, 12'd1, 1'b1);
        drv4(1'b1, 12'd1, 1'b1);
        drv4(1'b1, 12'd1, 1'b1);
        drv4(1'b1, 12'd1, 1'b1);
        drv4(1'b0, 12'd0, 1'b1);
        out4("t5.fresh", 1'b1, 12'd4, 1'b0);

        // K = 1 instance: every beat is a tile
        drv1(1'b1, 12'h123, 1'b1);
        chk("k1.rdy", 32'(bus1.in_ready), 32'd1);
        drv1(1'b1, 12'h456, 1'b1);
        out1("k1.a", 1'b1, 12'h123, 1'b0);
        drv1(1'b0, 12'h000, 1'b1);
        out1("k1.b", 1'b1, 12'h456, 1'b0);
        drv1(1'b0, 12'h000, 1'b1);
        out1("k1.idle", 1'b0, 12'h456, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
# psum_accum

Partial-sum accumulator that sits directly downstream of the 12-bit partial-sum adder in the TPU datapath. It accepts a stream of N-bit two's-complement partial sums, one per beat. It adds K consecutive beats into one tile result using wrap-around arithmetic, so the carry-out is discarded exactly as in the adder stage. Each tile result is presented on a one-entry registered output with valid/ready backpressure, and is flagged if any addition in the tile overflowed in the signed sense.

## Interface
Parameters:
- N, 12, data width of partial sums and of the result.
- K, 4, beats per tile; legal range K ≥ 1.
- CW, $clog2(K) (minimum 1), beat-counter width; derived, not overridden.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  in_data holds a valid partial sum.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  N  two's-complement partial sum.
- out_valid  output  1  out_data and out_ovf hold a completed tile.
- out_ready  input  1  consumer accepts the tile this cycle.
- out_data  output  N  tile sum, modulo 2^N.
- out_ovf  output  1  sticky signed-overflow flag for the presented tile.

## Operation
- A beat is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- FSM states:
  - IDLE: cnt=0, no tile in progress.
  - ACCUM: 0<cnt≤K-1.
- IDLE to ACCUM on an accepted beat when K>1. ACCUM to IDLE on an accepted beat with cnt==K-1. Otherwise the state holds.
- First beat of a tile: acc ← in_data, ovf_acc ← 0.
- Later beats: acc ← acc + in_data (mod 2^N).
  - ovf_acc ← ovf_acc | signed overflow of that add.
  - Signed overflow means both operands have the same sign and the sum has the opposite sign.
- Final beat (cnt==K-1, or any beat when K==1):
  - out_data ← final sum (in_data alone when K==1).
  - out_ovf ← accumulated flag including this add.
  - out_valid ← 1, cnt ← 0, state ← IDLE.
  - acc and ovf_acc are not loaded.
- in_ready = !(last_beat && out_valid && !out_ready), where last_beat = (cnt==K-1).
  - Non-final beats are never stalled by the output.
  - The final beat stalls only while the output slot is full and not draining.
- Same-cycle consumption and final-beat acceptance: the new tile replaces the old one and out_valid stays 1.
- Consumption with no new final beat: out_valid ← 0. out_data and out_ovf hold their last values.
- in_ready must not depend combinationally on in_valid.
- While in_valid==0, state, cnt, acc and ovf_acc hold.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_ovf=0.
  - cnt=0, acc=0, ovf_acc=0, state=IDLE.
  - in_ready=1 in the cycle after reset deasserts.
- Latency: final beat accepted in cycle t, so out_valid=1 and the result appear in cycle t+1.
- Throughput: one beat per cycle sustained with out_ready=1, with no bubbles between tiles.
- rst asserted mid-tile: the partial tile and any pending output are discarded. The next accepted beat starts a fresh tile.
- rst has priority over any simultaneous handshake.
- Wrap-around: 0x7FF + 0x001 = 0x800, and the add sets ovf.
- Output stability: out_data and out_ovf must not change while out_valid && !out_ready.

## Structure
- The shared package tpu_pkg holds:
  - localparam PSUM_W = 12;
  - typedef logic signed [PSUM_W-1:0] psum_t;
  - the FSM state enum typedef (IDLE, ACCUM).
- One sub-module, psum_add_ovf: a combinational N-bit wrap adder that outputs sum and signed-overflow. It is instantiated once in psum_accum.
- psum_accum itself holds the FSM, the beat counter, the accumulator register and the output register.

## Test plan
- K=4, out_ready=1, beats 1,2,3,4 back-to-back → one cycle after beat 4: out_valid=1, out_data=10, out_ovf=0 for one cycle.
- K=4, beats 0x7FF,0x001,0x000,0x000 → out_data=0x800, out_ovf=1. Next tile 5,−5,0,0 → out_data=0, out_ovf=0, showing the flag does not carry over.
- K=4, out_ready=0 after tile A (sum 4) completes; stream tile B → beats 1–3 of B accepted, in_ready=0 on B's final beat. Raise out_ready → A consumed in that cycle, B's final beat accepted, B valid next cycle, A's value stable throughout the stall.
- K=4, out_ready=1, stream 8 beats of value −1 (0xFFF) continuously → two results of 0xFFC, in_ready never drops, out_ovf=0.
- rst pulse after 2 of 4 beats, with a pending unconsumed output → out_valid=0 the next cycle. Beats 1,1,1,1 afterwards → out_data=4.
- K=1 build: beats 0x123, then 0x456 with out_ready=1 → outputs 0x123, 0x456 one cycle after each beat, out_ovf=0.
